branch_predictor_btb: RTL
=========================

BRANCH_PREDICTOR_BTB -- requirements
Module: branch_predictor_btb

Interface
REQ-001 SHALL provide parameter ENTRIES, default 16: BTB depth, power of two, 4..256; IDX_W = log2(ENTRIES), TAG_W = 30-IDX_W.
REQ-002 SHALL provide parameter DATA_W, default 8: width of compared register operands.
REQ-003 SHALL provide parameter SIGNED_CMP, default 0: 1 makes BLT/BGE compare operands as two's-complement.
REQ-004 SHALL provide ports, one per line as name  direction  width  meaning:
 clk  in  1  single clock, rising edge.
 rst_n  in  1  asynchronous, active-low reset.
 IF_pc  in  32  fetch PC for lookup.
 IF_pred_taken  out  1  predict taken for IF_pc.
 IF_pred_target  out  32  predicted next PC; IF_pc+4 when not taken.
 ID_valid  in  1  ID stage holds a real, non-stalled instruction.
 ID_instruction  in  32  ID instruction word.
 ID_pcplus4  in  32  ID PC+4.
 ID_read_data1  in  DATA_W  rs operand.
 ID_read_data2  in  DATA_W  rt operand.
 ID_pred_taken  in  1  prediction carried through IF/ID.
 ID_pred_target  in  32  target carried through IF/ID.
 pc_addr  out  32  corrected PC on mispredict.
 pcsrc  out  1  select pc_addr for the next fetch.
 IFID_flush  out  1  flush IF/ID register.

Function
REQ-005 SHALL decode opcode ID_instruction[31:26]: JUMP 100011, BEQ 000100, BNE 000001, BLT 000011, BGE 000101; all other values are non-control.
REQ-006 SHALL compute jump target {ID_pcplus4[31:28], instr[25:0], 2'b00} and branch target ID_pcplus4 + sign-extended instr[15:0] shifted left 2, modulo 2^32.
REQ-007 SHALL resolve actual_taken: JUMP always; BEQ equal; BNE unequal; BLT rs<rt; BGE not rs<rt; non-control never.
REQ-008 SHALL hold per entry: valid, TAG_W tag, 32-bit target, 2-bit saturating counter.
REQ-009 SHALL look up combinationally, index IF_pc[IDX_W+1:2], tag IF_pc[31:IDX_W+2]; predict taken iff valid, tag match and counter[1]=1.
REQ-010 SHALL derive ID_pc = ID_pcplus4-4 and use its index/tag for updates.
REQ-011 SHALL flag mispredict when ID_valid and (actual_taken != ID_pred_taken, or both taken and ID_pred_target != actual target).
REQ-012 SHALL on mispredict drive pcsrc=1, IFID_flush=1, pc_addr = actual target if taken else ID_pcplus4, same cycle (combinational); otherwise pcsrc=0, IFID_flush=0, pc_addr=ID_pcplus4.
REQ-013 SHALL drive pcsrc=0 and IFID_flush=0 whenever ID_valid=0.
REQ-014 SHALL update at the rising edge only when ID_valid=1, per REQ-015..018.
REQ-015 On control instruction with tag hit: target written with actual target if taken; counter +1 saturating at 11 if taken, -1 saturating at 00 if not.
REQ-016 On taken control instruction with miss: allocate (overwrite), valid=1, counter 11 for JUMP, 10 for branches.
REQ-017 On not-taken branch with miss: no write.
REQ-018 On non-control instruction with ID_pred_taken=1 (alias): clear valid of that index.
REQ-019 Same-index IF lookup and ID update in one cycle SHALL return pre-update contents (no bypass).

Reset
REQ-020 rst_n=0 SHALL asynchronously clear every valid bit and set counters to 01; tags/targets don't-care.
REQ-021 During reset outputs SHALL follow REQ-009..013 with empty table (IF_pred_taken=0, IF_pred_target=IF_pc+4).
REQ-022 Reset deassertion mid-stream SHALL require no warm-up; first edge after release may update.

Configuration
REQ-023 Macro BPU_STATS_EN defined SHALL add outputs stat_branches and stat_mispredicts (16 bits each), counting ID_valid control instructions and mispredicts, saturating at FFFF, cleared by reset.
REQ-024 BPU_STATS_EN undefined SHALL omit those ports and counters; all other behaviour identical.

Verification
REQ-025 After reset, IF_pc=0x100 -> IF_pred_taken=0, IF_pred_target=0x104.
REQ-026 BEQ at 0x100, offset 4, rs=rt=5, ID_pred_taken=0 -> pcsrc=1, IFID_flush=1, pc_addr=0x114; next cycle IF_pc=0x100 predicts 0x114.
REQ-027 Same BEQ then not-taken twice (rs=1,rt=2) -> counter 10->01->00; lookup predicts not taken after first.
REQ-028 SIGNED_CMP=1, BLT rs=0xFF, rt=0x01 -> taken; SIGNED_CMP=0 -> not taken.
REQ-029 Non-control at aliased PC with ID_pred_taken=1 -> pc_addr=ID_pcplus4, flush, entry invalidated next cycle.
REQ-030 With BPU_STATS_EN, 3 branches, 1 mispredict -> stat_branches=3, stat_mispredicts=1; rst_n pulse mid-run -> both 0.

Source files
------------

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit counters; branches resolve in ID.
// Optional BPU_STATS_EN adds branch/mispredict counters.
module branch_predictor_btb #(
  parameter int ENTRIES    = 16,
  parameter int DATA_W     = 8,
  parameter int SIGNED_CMP = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       IF_pc,
  output logic              IF_pred_taken,
  output logic [31:0]       IF_pred_target,
  input  logic              ID_valid,
  input  logic [31:0]       ID_instruction,
  input  logic [31:0]       ID_pcplus4,
  input  logic [DATA_W-1:0] ID_read_data1,
  input  logic [DATA_W-1:0] ID_read_data2,
  input  logic              ID_pred_taken,
  input  logic [31:0]       ID_pred_target,
  output logic [31:0]       pc_addr,
  output logic              pcsrc,
  output logic              IFID_flush
`ifdef BPU_STATS_EN
  ,
  output logic [15:0]       stat_branches,
  output logic [15:0]       stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [2:0] {
    OP_NONE, OP_JUMP, OP_BEQ, OP_BNE, OP_BLT, OP_BGE
  } op_e;

  logic [ENTRIES-1:0] valid_q;
  logic [1:0]         ctr_q [ENTRIES];
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];

  op_e        op;
  logic [5:0] opc;
  logic       is_ctrl;
  logic       is_jump;
  logic       lt;
  logic       eq;
  logic       act_taken;
  logic [31:0] br_tgt;
  logic [31:0] jmp_tgt;
  logic [31:0] act_tgt;
  logic [31:0] id_pc;
  logic [IDX_W-1:0] id_idx;
  logic [TAG_W-1:0] id_tag;
  logic       id_hit;
  logic       mispredict;
  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic       if_hit;
  logic       unused;

  assign opc = ID_instruction[31:26];

  always_comb begin
    op = OP_NONE;
    unique case (1'b1)
      (opc == 6'b100011): op = OP_JUMP;
      (opc == 6'b000100): op = OP_BEQ;
      (opc == 6'b000001): op = OP_BNE;
      (opc == 6'b000011): op = OP_BLT;
      (opc == 6'b000101): op = OP_BGE;
      default:            op = OP_NONE;
    endcase
  end

  assign is_ctrl = (op != OP_NONE);
  assign is_jump = (op == OP_JUMP);
  assign eq = (ID_read_data1 == ID_read_data2);
  assign lt = (SIGNED_CMP != 0)
            ? ($signed(ID_read_data1) < $signed(ID_read_data2))
            : (ID_read_data1 < ID_read_data2);

  always_comb begin
    act_taken = 1'b0;
    unique case (op)
      OP_JUMP: act_taken = 1'b1;
      OP_BEQ:  act_taken = eq;
      OP_BNE:  act_taken = !eq;
      OP_BLT:  act_taken = lt;
      OP_BGE:  act_taken = !lt;
      default: act_taken = 1'b0;
    endcase
  end

  assign jmp_tgt = {ID_pcplus4[31:28], ID_instruction[25:0], 2'b00};
  assign br_tgt  = ID_pcplus4
                 + {{14{ID_instruction[15]}}, ID_instruction[15:0], 2'b00};
  assign act_tgt = is_jump ? jmp_tgt : br_tgt;

  assign id_pc  = ID_pcplus4 - 32'd4;
  assign id_idx = id_pc[IDX_W+1:2];
  assign id_tag = id_pc[31:IDX_W+2];
  assign id_hit = valid_q[id_idx] && (tag_q[id_idx] == id_tag);

  assign mispredict = ID_valid
    && ((act_taken != ID_pred_taken)
     || (act_taken && ID_pred_taken && (ID_pred_target != act_tgt)));

  assign pcsrc      = mispredict;
  assign IFID_flush = mispredict;
  assign pc_addr    = (mispredict && act_taken) ? act_tgt : ID_pcplus4;

  // Lookup reads the registered table, so a same-cycle update is not seen.
  assign if_idx = IF_pc[IDX_W+1:2];
  assign if_tag = IF_pc[31:IDX_W+2];
  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag)
               && ctr_q[if_idx][1];
  assign IF_pred_taken  = if_hit;
  assign IF_pred_target = if_hit ? tgt_q[if_idx] : IF_pc + 32'd4;

  assign unused = ^{IF_pc[1:0], id_pc[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
    end else if (ID_valid) begin
      if (is_ctrl && id_hit) begin
        if (act_taken && ctr_q[id_idx] != 2'b11)
          ctr_q[id_idx] <= ctr_q[id_idx] + 2'b01;
        else if (!act_taken && ctr_q[id_idx] != 2'b00)
          ctr_q[id_idx] <= ctr_q[id_idx] - 2'b01;
      end else if (is_ctrl && act_taken) begin
        valid_q[id_idx] <= 1'b1;
        ctr_q[id_idx]   <= is_jump ? 2'b11 : 2'b10;
      end else if (!is_ctrl && ID_pred_taken) begin
        valid_q[id_idx] <= 1'b0;
      end
    end
  end

  // Tag/target need no reset; valid gates their use.
  always_ff @(posedge clk) begin
    if (rst_n && ID_valid && is_ctrl && act_taken) begin
      tgt_q[id_idx] <= act_tgt;
      tag_q[id_idx] <= id_tag;
    end
  end

`ifdef BPU_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (ID_valid) begin
      if (is_ctrl && stat_branches != 16'hFFFF)
        stat_branches <= stat_branches + 16'd1;
      if (mispredict && stat_mispredicts != 16'hFFFF)
        stat_mispredicts <= stat_mispredicts + 16'd1;
    end
  end
`endif

endmodule
